// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared states, response codes and error causes for the register-bus initiator.
package reg_bus_pkg;
  typedef enum logic [2:0] {IDLE, RX_DATA, RX_CHK, WR, RD, TX0, TX1} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_CHK, ERR_TMO, ERR_MODE} err_code_t;
  localparam logic [7:0] ACK = 8'h5A;
  localparam logic [7:0] NACK = 8'hA5;
  localparam logic [7:0] CHK_SALT = 8'hA5;
endpackage

// File: rtl/reg_bus_mst.sv
// reg_bus_mst: parses host command frames into register write/read strobes and streams back responses.
module reg_bus_mst import reg_bus_pkg::*; #(
  parameter int AW = 7,
  parameter int DW = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rx_vld,
  input  logic [7:0]    i_rx_data,
  output logic          o_rx_rdy,
  output logic          o_tx_vld,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_rdy,
  output logic          o_wen,
  output logic          o_ren,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  input  logic [DW-1:0] i_rdata,
  input  logic          i_test_mode_status,
  input  logic          i_cfg_mode_status,
  output logic          o_busy,
  output logic          o_err,
  output logic [1:0]    o_err_code
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state;
  err_code_t code;
  logic up, is_wr, acc, chk_ok, hs;
  logic [7:0] cmd;
  logic [TW-1:0] tmo;
  // up keeps o_rx_rdy low while reset is asserted so every output reads 0
  assign o_rx_rdy = up && (state == IDLE || state == RX_DATA || state == RX_CHK);
  assign acc = i_rx_vld && o_rx_rdy;
  assign hs = o_tx_vld && i_tx_rdy;
  assign o_busy = state != IDLE;
  assign o_err_code = code;
  // address bits above AW must be zero for the frame to count as well-formed
  assign chk_ok = i_rx_data == (cmd ^ o_wdata ^ CHK_SALT) && (cmd[6:0] >> AW) == '0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      code <= ERR_NONE;
      up <= 1'b0;
      is_wr <= 1'b0;
      cmd <= '0;
      tmo <= '0;
      o_tx_vld <= 1'b0;
      o_tx_data <= '0;
      o_wen <= 1'b0;
      o_ren <= 1'b0;
      o_addr <= '0;
      o_wdata <= '0;
      o_err <= 1'b0;
    end else begin
      up <= 1'b1;
      o_wen <= 1'b0;
      o_ren <= 1'b0;
      o_err <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          cmd <= i_rx_data;
          o_addr <= i_rx_data[AW-1:0];
          is_wr <= i_rx_data[7];
          tmo <= '0;
          o_ren <= !i_rx_data[7];
          state <= i_rx_data[7] ? RX_DATA : RD;
        end
        RX_DATA, RX_CHK: if (acc) begin
          tmo <= '0;
          if (state == RX_DATA) begin
            o_wdata <= i_rx_data;
            state <= RX_CHK;
          end else begin
            state <= WR;
            o_wen <= chk_ok && (i_test_mode_status || i_cfg_mode_status);
            o_err <= !chk_ok || !(i_test_mode_status || i_cfg_mode_status);
            o_tx_data <= (chk_ok && (i_test_mode_status || i_cfg_mode_status)) ? ACK : NACK;
            if (!chk_ok) code <= ERR_CHK;
            else if (!(i_test_mode_status || i_cfg_mode_status)) code <= ERR_MODE;
          end
        end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          state <= IDLE;
          tmo <= '0;
          o_err <= 1'b1;
          code <= ERR_TMO;
        end else begin
          tmo <= tmo + 1'b1;
        end
        WR: begin
          o_tx_vld <= 1'b1;
          state <= TX0;
        end
        RD: begin
          o_tx_data <= i_rdata;
          o_tx_vld <= 1'b1;
          state <= TX0;
        end
        TX0: if (hs) begin
          o_tx_vld <= !is_wr;
          o_tx_data <= is_wr ? o_tx_data : ~o_tx_data;
          state <= is_wr ? IDLE : TX1;
        end
        TX1: if (hs) begin
          o_tx_vld <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bus_mst.sv
// tb_reg_bus_mst: randomized frames checked against a frame-level reference model.
module tb_reg_bus_mst;
  localparam int AW = 7, DW = 8, TMO = 24;
  logic i_clk = 0, i_rst_n = 0, i_rx_vld = 0, i_tx_rdy = 0;
  logic i_test_mode_status = 0, i_cfg_mode_status = 0;
  logic [7:0] i_rx_data = 0, rd_val = 0;
  logic [DW-1:0] i_rdata;
  logic o_rx_rdy, o_tx_vld, o_wen, o_ren, o_busy, o_err;
  logic [7:0] o_tx_data;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata;
  logic [1:0] o_err_code;

  reg_bus_mst #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_vld(i_rx_vld), .i_rx_data(i_rx_data),
    .o_rx_rdy(o_rx_rdy), .o_tx_vld(o_tx_vld), .o_tx_data(o_tx_data), .i_tx_rdy(i_tx_rdy),
    .o_wen(o_wen), .o_ren(o_ren), .o_addr(o_addr), .o_wdata(o_wdata), .i_rdata(i_rdata),
    .i_test_mode_status(i_test_mode_status), .i_cfg_mode_status(i_cfg_mode_status),
    .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 i_clk = ~i_clk;
  assign i_rdata = o_ren ? rd_val : '0;

  int vec = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] txq[$];
  int n_wen = 0, n_ren = 0, n_err = 0, rdy_pct = 100;
  bit stall = 0;
  logic pv = 0, ph = 0;
  logic [7:0] pd = 0, wen_addr = 0, wen_data = 0;
  logic [1:0] exp_code = 0;

  always @(negedge i_clk) begin
    if (o_tx_vld && pv && !ph) chk("tx_hold", o_tx_data, pd);
    if (o_tx_vld) chk("rx_stall", o_rx_rdy, 0);
    i_tx_rdy = !stall && ($urandom_range(99) < rdy_pct);
    if (o_tx_vld && i_tx_rdy) txq.push_back(o_tx_data);
    pv = o_tx_vld;
    ph = i_tx_rdy;
    pd = o_tx_data;
    if (o_wen) begin
      n_wen++;
      wen_addr = 8'(o_addr);
      wen_data = o_wdata;
    end
    if (o_ren) n_ren++;
    if (o_err) n_err++;
  end

  task automatic clr();
    n_wen = 0; n_ren = 0; n_err = 0;
    txq.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge i_clk);
    i_rx_vld = 1; i_rx_data = b;
    while (!o_rx_rdy && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_rx_rdy) chk("rx_rdy_wait", o_rx_rdy, 1);
    @(posedge i_clk); #1;
    i_rx_vld = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge i_clk);
    while (o_busy && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    chk("done", o_busy, 0);
  endtask

  task automatic check_tx(input logic [7:0] eq[$]);
    chk("tx_count", txq.size(), eq.size());
    foreach (eq[i]) if (i < txq.size()) chk("tx_byte", txq[i], eq[i]);
  endtask

  // kind: 0 read, 1 write with good checksum, 2 write with corrupted checksum
  task automatic frame(input int kind, input logic [6:0] a, input logic [7:0] d, input bit tm, input bit cm);
    logic [7:0] cmd, c;
    logic [7:0] eq[$];
    int ew = 0, er = 0, ee = 0;
    clr();
    i_test_mode_status = tm; i_cfg_mode_status = cm;
    cmd = {kind != 0, a};
    c = cmd ^ d ^ 8'hA5;
    if (kind == 2) c = c ^ 8'($urandom_range(1, 255));
    if (kind == 0) begin
      rd_val = d; er = 1;
      eq.push_back(d); eq.push_back(~d);
    end else if (kind == 2) begin
      ee = 1; exp_code = 1; eq.push_back(8'hA5);
    end else if (tm || cm) begin
      ew = 1; eq.push_back(8'h5A);
    end else begin
      ee = 1; exp_code = 3; eq.push_back(8'hA5);
    end
    send(cmd);
    if (kind != 0) begin
      send(d);
      send(c);
    end
    wait_idle();
    chk("wen_pulses", n_wen, ew);
    chk("ren_pulses", n_ren, er);
    chk("err_pulses", n_err, ee);
    chk("err_code", o_err_code, exp_code);
    chk("addr", o_addr, a);
    if (kind != 0) chk("wdata", o_wdata, d);
    if (ew == 1) chk("wen_addr_data", {wen_addr, wen_data}, {1'b0, a, d});
    check_tx(eq);
  endtask

  task automatic timeout(input logic [6:0] a, input logic [7:0] d, input bit with_data);
    int n = 0;
    clr();
    send({1'b1, a});
    if (with_data) send(d);
    while (!o_err && n < TMO + 10) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("tmo_cycles", n, TMO);
    exp_code = 2;
    @(negedge i_clk);
    chk("tmo_code", o_err_code, exp_code);
    chk("tmo_rx_rdy", o_rx_rdy, 1);
    chk("tmo_busy", o_busy, 0);
    repeat (3) @(negedge i_clk);
    chk("tmo_err_pulses", n_err, 1);
    chk("tmo_wen", n_wen, 0);
    chk("tmo_tx", txq.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk(tag, {o_rx_rdy, o_tx_vld, o_tx_data, o_wen, o_ren, o_addr, o_wdata, o_busy, o_err, o_err_code}, 0);
  endtask

  initial begin
    logic [7:0] eq[$];
    repeat (3) @(negedge i_clk);
    check_reset_outs("reset_outs");
    i_rst_n = 1;
    repeat (2) @(negedge i_clk);
    chk("rx_rdy_idle", o_rx_rdy, 1);
    frame(1, 7'd3, 8'h3C, 0, 1);
    frame(0, 7'd3, 8'h3C, 0, 0);
    chk("busy_after_read", o_busy, 0);
    frame(2, 7'd3, 8'h3C, 0, 1);
    frame(1, 7'd9, 8'hE1, 0, 0);
    timeout(7'd5, 8'h77, 1);
    frame(0, 7'd5, 8'h4B, 1, 0);
    timeout(7'd6, 8'h00, 0);
    frame(1, 7'd127, 8'hFF, 1, 0);
    // hold off the serializer while the first read byte is pending
    clr();
    stall = 1; rd_val = 8'h96;
    send(8'h05);
    for (int n = 0; n < 20 && !o_tx_vld; n++) @(negedge i_clk);
    chk("stall_vld", o_tx_vld, 1);
    repeat (10) begin
      @(negedge i_clk);
      chk("stall_data", o_tx_data, 8'h96);
      chk("stall_rx_rdy", o_rx_rdy, 0);
    end
    stall = 0;
    wait_idle();
    eq = {8'h96, 8'h69};
    check_tx(eq);
    // abort a write frame with reset partway through
    clr();
    i_cfg_mode_status = 1;
    send(8'h85);
    send(8'h11);
    @(negedge i_clk);
    i_rst_n = 0;
    #1;
    check_reset_outs("midframe_reset_outs");
    exp_code = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1;
    repeat (6) @(negedge i_clk);
    chk("post_reset_wen", n_wen, 0);
    chk("post_reset_tx", txq.size(), 0);
    frame(1, 7'd5, 8'h11, 0, 1);
    for (int i = 0; i < 40; i++) begin
      int k;
      bit tm, cm;
      rdy_pct = $urandom_range(30, 100);
      k = $urandom_range(3);
      tm = 1'($urandom); cm = 1'($urandom);
      if (k == 1 && !(tm || cm)) cm = 1;
      if (k == 3) begin
        tm = 0; cm = 0; k = 1;
      end
      frame(k, 7'($urandom), 8'($urandom), tm, cm);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
